// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 definitions for the piano keyboard path: prefix bytes,
// parser states and key id / note encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam int         KEY_W     = 9;
  localparam int         NOTE_NONE = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXT    = 2'd1,
    BRK    = 2'd2,
    EXTBRK = 2'd3
  } parseState_e;

endpackage

// File: rtl/ps2_note_map.sv
// Combinational key id {ext, code} -> note lookup; NOTE_NONE marks an
// unmapped key. Shared with the legacy mono decoder.
module ps2_note_map
  import ps2_pkg::*;
#(
  parameter int NOTE_W = 8
) (
  input  logic [KEY_W-1:0]  keyId,
  output logic [NOTE_W-1:0] note
);

  // Key id to note table
  always_comb begin
    note = NOTE_W'(NOTE_NONE);
    case (keyId)
      9'h171:  note = NOTE_W'(8'd36);
      9'h169:  note = NOTE_W'(8'd38);
      9'h17A:  note = NOTE_W'(8'd40);
      9'h170:  note = NOTE_W'(8'd41);
      9'h16C:  note = NOTE_W'(8'd43);
      9'h17D:  note = NOTE_W'(8'd45);
      9'h14A:  note = NOTE_W'(8'd31);
      9'h075:  note = NOTE_W'(8'd24);
      9'h07D:  note = NOTE_W'(8'd26);
      9'h079:  note = NOTE_W'(8'd28);
      9'h077:  note = NOTE_W'(8'd29);
      9'h07C:  note = NOTE_W'(8'd33);
      9'h07B:  note = NOTE_W'(8'd35);
      default: note = NOTE_W'(NOTE_NONE);
    endcase
  end

endmodule

// File: rtl/ps2_poly_keymap.sv
// Polyphonic PS/2 keymap: parses make/break sequences (with E0 prefix) and
// holds up to CHANNELS keys, one note per slot, for the tone generators.
module ps2_poly_keymap
  import ps2_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int NOTE_W   = 8
) (
  input  logic                       iClk,
  input  logic                       iReset_n,
  input  logic                       iFlag,
  input  logic [7:0]                 iData,
  output logic [CHANNELS*NOTE_W-1:0] oNote,
  output logic [CHANNELS-1:0]        oActive,
  output logic                       oKeyOn,
  output logic                       oKeyOff,
  output logic                       oOverflow
);

  parseState_e parseState;
  parseState_e parseNext;
  logic isMake;
  logic isBreak;
  logic isExt;
  logic [KEY_W-1:0]    keyId;
  logic [NOTE_W-1:0]   mapNote;
  logic [CHANNELS-1:0] hitVec;
  logic [CHANNELS-1:0] activeVec;
  logic [CHANNELS-1:0] freeVec;
  logic [CHANNELS-1:0] lowFree;
  logic allocEn;
  logic overflowEn;
  logic releaseEn;

  // Parser next state and make/break event decode for the byte on iData
  always_comb begin
    parseNext = parseState;
    isMake    = 1'b0;
    isBreak   = 1'b0;
    isExt     = 1'b0;
    if (iFlag) begin
      case (parseState)
        IDLE: begin
          if (iData == PS2_EXT) begin
            parseNext = EXT;
          end else if (iData == PS2_BRK) begin
            parseNext = BRK;
          end else begin
            isMake = 1'b1;
          end
        end
        EXT: begin
          if (iData == PS2_BRK) begin
            parseNext = EXTBRK;
          end else if (iData == PS2_EXT) begin
            parseNext = EXT;
          end else begin
            isMake    = 1'b1;
            isExt     = 1'b1;
            parseNext = IDLE;
          end
        end
        BRK: begin
          if (iData == PS2_BRK) begin
            parseNext = BRK;
          end else if (iData == PS2_EXT) begin
            parseNext = EXTBRK;
          end else begin
            isBreak   = 1'b1;
            parseNext = IDLE;
          end
        end
        EXTBRK: begin
          if ((iData == PS2_BRK) || (iData == PS2_EXT)) begin
            parseNext = EXTBRK;
          end else begin
            isBreak   = 1'b1;
            isExt     = 1'b1;
            parseNext = IDLE;
          end
        end
        default: parseNext = IDLE;
      endcase
    end else begin
      parseNext = parseState;
    end
  end

  assign keyId = {isExt, iData};

  ps2_note_map #(.NOTE_W(NOTE_W)) uNoteMap (
    .keyId (keyId),
    .note  (mapNote)
  );

  // Isolate the lowest set bit of the free mask: x & -x
  assign freeVec    = ~activeVec;
  assign lowFree    = freeVec & (~freeVec + CHANNELS'(1));
  assign allocEn    = isMake && (mapNote != NOTE_W'(NOTE_NONE)) && !(|hitVec) && (|freeVec);
  assign overflowEn = isMake && (mapNote != NOTE_W'(NOTE_NONE)) && !(|hitVec) && !(|freeVec);
  assign releaseEn  = isBreak && (|hitVec);
  assign oActive    = activeVec;

  for (genvar k = 0; k < CHANNELS; k++) begin : gSlot
    logic [KEY_W-1:0]  idR;
    logic [NOTE_W-1:0] noteR;
    logic              activeR;

    assign hitVec[k]                  = activeR && (idR == keyId);
    assign activeVec[k]               = activeR;
    assign oNote[k*NOTE_W +: NOTE_W]  = noteR;

    // Slot k: take a new key when chosen as lowest free, drop it on its break
    always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
        idR     <= '0;
        noteR   <= NOTE_W'(NOTE_NONE);
        activeR <= 1'b0;
      end else if (allocEn && lowFree[k]) begin
        idR     <= keyId;
        noteR   <= mapNote;
        activeR <= 1'b1;
      end else if (releaseEn && hitVec[k]) begin
        noteR   <= NOTE_W'(NOTE_NONE);
        activeR <= 1'b0;
      end else begin
        activeR <= activeR;
      end
    end
  end

  // Parser state and one-cycle event pulses
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      parseState <= IDLE;
      oKeyOn     <= 1'b0;
      oKeyOff    <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      parseState <= parseNext;
      oKeyOn     <= allocEn;
      oKeyOff    <= releaseEn;
      oOverflow  <= overflowEn;
    end
  end

endmodule
